store_stage: RTL and testbench

//  Last pipeline stage of the SHAKE core: the transmit-side counterpart of the load stage. Accepts full-rate

---
 rtl/keccak_pkg.sv | 36 +++
 rtl/store_datapath.sv | 108 ++++++++++
 rtl/store_fsm.sv | 94 +++++++++
 rtl/store_stage.sv | 84 ++++++++
 tb/tb_store_stage.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keccak_pkg.sv
// keccak_pkg: shared constants and types for the SHAKE core store stage.
//   w               output word width (64)
//   RATE_SHAKE128   SHAKE128 rate in bits (1344, 21 words)
//   RATE_SHAKE256   SHAKE256 rate in bits (1088, 17 words)
//   WPB_128/WPB_256 words per squeezed block for each mode
//   mode_e          operation mode encoding
//   store_state_e   store stage FSM states
//   words_for_size  ceil(size/w) computed without 32-bit overflow
package keccak_pkg;
    localparam int w             = 64;
    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;
    localparam int WPB_128       = RATE_SHAKE128 / w;
    localparam int WPB_256       = RATE_SHAKE256 / w;
    localparam int WL_W          = 27;  // holds ceil((2^32-1)/64) = 2^26
    localparam int IDX_W         = 5;   // word index within a block, 0..20

    typedef enum logic [1:0] {
        MODE_SHAKE128 = 2'b00,
        MODE_SHAKE256 = 2'b01
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_BLK = 2'd1,
        ST_DUMP     = 2'd2,
        ST_DONE     = 2'd3
    } store_state_e;

    // Round up in 33 bits so size=32'hFFFF_FFFF does not wrap.
    function automatic logic [WL_W-1:0] words_for_size(input logic [31:0] size);
        logic [32:0] sum;
        sum = {1'b0, size} + 33'(w - 1);
        return sum[32:$clog2(w)];
    endfunction
endpackage

// File: rtl/store_datapath.sv
// store_datapath: block shift register and job counters for the store stage.
//   Build option STORE_TAIL_MASK_EN: zero bits [W-1:r] of the final word,
//   r = output_size % W (no mask when r == 0). Without it the final word
//   carries raw squeezed state in its unused bits.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   block_in        squeezed block, word 0 in bits [W-1:0]
//   output_size     job length in bits, sampled on load_first_i
//   operation_mode  mode, sampled on load_first_i (non-SHAKE128 -> SHAKE256)
//   load_first_i    capture first block, size and mode
//   load_next_i     capture a follow-on block
//   shift_i         word transferred: advance to next word
//   word_o          current word (masked when enabled and final)
//   size_zero_o     output_size == 0 (for the job being started)
//   last_word_o     words_left == 1
//   blk_end_o       word_idx == WPB-1
//   last_blk_o      words_left <= WPB
module store_datapath
    import keccak_pkg::*;
#(
    parameter int W        = w,
    parameter int RATE_MAX = RATE_SHAKE128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RATE_MAX-1:0] block_in,
    input  logic [31:0]         output_size,
    input  logic [1:0]          operation_mode,
    input  logic                load_first_i,
    input  logic                load_next_i,
    input  logic                shift_i,
    output logic [W-1:0]        word_o,
    output logic                size_zero_o,
    output logic                last_word_o,
    output logic                blk_end_o,
    output logic                last_blk_o
);
    logic [RATE_MAX-1:0] buffer_q, buffer_d;
    logic [IDX_W-1:0]    word_idx_q, word_idx_d;
    logic [WL_W-1:0]     words_left_q, words_left_d;
    logic                is_128_q, is_128_d;
    logic [IDX_W-1:0]    wpb_m1;
    logic [WL_W-1:0]     wpb;
`ifdef STORE_TAIL_MASK_EN
    localparam int RW = $clog2(W);
    logic [RW-1:0]       tail_r_q, tail_r_d;
`endif

    always_comb begin
        buffer_d     = buffer_q;
        word_idx_d   = word_idx_q;
        words_left_d = words_left_q;
        is_128_d     = is_128_q;
`ifdef STORE_TAIL_MASK_EN
        tail_r_d     = tail_r_q;
`endif
        if (load_first_i || load_next_i) begin
            buffer_d   = block_in;
            word_idx_d = '0;
        end
        if (load_first_i) begin
            words_left_d = words_for_size(output_size);
            is_128_d     = (operation_mode == MODE_SHAKE128);
`ifdef STORE_TAIL_MASK_EN
            tail_r_d     = output_size[RW-1:0];
`endif
        end
        if (shift_i) begin
            buffer_d     = buffer_q >> W;
            word_idx_d   = word_idx_q + IDX_W'(1);
            words_left_d = words_left_q - WL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer_q     <= '0;
            word_idx_q   <= '0;
            words_left_q <= '0;
            is_128_q     <= 1'b0;
`ifdef STORE_TAIL_MASK_EN
            tail_r_q     <= '0;
`endif
        end else begin
            buffer_q     <= buffer_d;
            word_idx_q   <= word_idx_d;
            words_left_q <= words_left_d;
            is_128_q     <= is_128_d;
`ifdef STORE_TAIL_MASK_EN
            tail_r_q     <= tail_r_d;
`endif
        end
    end

    always_comb begin
        wpb_m1      = is_128_q ? IDX_W'(WPB_128 - 1) : IDX_W'(WPB_256 - 1);
        wpb         = is_128_q ? WL_W'(WPB_128) : WL_W'(WPB_256);
        size_zero_o = (output_size == 32'd0);
        last_word_o = (words_left_q == WL_W'(1));
        blk_end_o   = (word_idx_q == wpb_m1);
        last_blk_o  = (words_left_q <= wpb);
        word_o      = buffer_q[W-1:0];
`ifdef STORE_TAIL_MASK_EN
        if (last_word_o && (tail_r_q != '0))
            word_o = word_o & ~({W{1'b1}} << tail_r_q);
`endif
    end
endmodule

// File: rtl/store_fsm.sv
// store_fsm: control for the store stage.
//   Handshakes: a block is accepted when block_valid_i && block_ready_o in
//   the same cycle; a word is transferred when valid_o && ready_i in the same
//   cycle. Neither side may depend on its own handshake partner combinationally.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   block_valid_i     upstream holds a block
//   ready_i           downstream accepts a word
//   size_zero_i       job being started has output_size == 0
//   last_word_i       word on the output is the job's final word
//   blk_end_i         word on the output is the last word of the held block
//   block_ready_o     registered: can capture a block (IDLE / WAIT_BLK)
//   valid_o           registered: word valid (DUMP)
//   job_done_o        registered: one-cycle pulse (DONE)
//   load_first_o      capture the first block of a job (samples size/mode)
//   load_next_o       capture a follow-on block of the current job
//   shift_o           a word was transferred this cycle
//   state_o           current state (debug / observation)
module store_fsm
    import keccak_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         block_valid_i,
    input  logic         ready_i,
    input  logic         size_zero_i,
    input  logic         last_word_i,
    input  logic         blk_end_i,
    output logic         block_ready_o,
    output logic         valid_o,
    output logic         job_done_o,
    output logic         load_first_o,
    output logic         load_next_o,
    output logic         shift_o,
    output store_state_e state_o
);
    store_state_e state_q, state_d;
    logic         block_ready_q, block_ready_d;
    logic         valid_q, valid_d;
    logic         job_done_q, job_done_d;
    logic         accept;
    logic         transfer;

    always_comb begin
        accept       = block_valid_i && block_ready_q;
        transfer     = valid_q && ready_i;
        load_first_o = accept && (state_q == ST_IDLE);
        load_next_o  = accept && (state_q == ST_WAIT_BLK);
        shift_o      = transfer;

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = size_zero_i ? ST_DONE : ST_DUMP;
            end
            ST_WAIT_BLK: begin
                if (accept) state_d = ST_DUMP;
            end
            ST_DUMP: begin
                // Job end wins over block end: a final word that is also the
                // block's last word must not wait for another block.
                if (transfer) begin
                    if (last_word_i)    state_d = ST_DONE;
                    else if (blk_end_i) state_d = ST_WAIT_BLK;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs decoded from the next state so they are flops aligned with state_q.
        block_ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT_BLK);
        valid_d       = (state_d == ST_DUMP);
        job_done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            block_ready_q <= 1'b1;
            valid_q       <= 1'b0;
            job_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            block_ready_q <= block_ready_d;
            valid_q       <= valid_d;
            job_done_q    <= job_done_d;
        end
    end

    assign block_ready_o = block_ready_q;
    assign valid_o       = valid_q;
    assign job_done_o    = job_done_q;
    assign state_o       = state_q;
endmodule

// File: rtl/store_stage.sv
// store_stage: last stage of the SHAKE core. Serializes squeezed blocks into
// ceil(output_size/W) W-bit words on a valid/ready output.
//   Build option STORE_TAIL_MASK_EN: zero unused bits of the final word.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   block_in         squeezed block, word 0 in bits [W-1:0]
//   block_valid_i    upstream holds a block
//   output_size      job length in bits, sampled on the first block
//   operation_mode   MODE_SHAKE128 / MODE_SHAKE256 (others -> SHAKE256)
//   block_ready_o    stage can capture a block
//   last_block_o     held block is the job's final block (DUMP only)
//   data_out         output word (0 when not valid)
//   valid_o          data_out valid
//   ready_i          downstream accepts word
//   last_o           final word of job (with valid_o)
//   job_done_o       one-cycle pulse after the final transfer
module store_stage
    import keccak_pkg::*;
#(
    parameter int W        = w,
    parameter int RATE_MAX = RATE_SHAKE128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RATE_MAX-1:0] block_in,
    input  logic                block_valid_i,
    input  logic [31:0]         output_size,
    input  logic [1:0]          operation_mode,
    output logic                block_ready_o,
    output logic                last_block_o,
    output logic [W-1:0]        data_out,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                last_o,
    output logic                job_done_o
);
    store_state_e state;
    logic         load_first;
    logic         load_next;
    logic         shift;
    logic         size_zero;
    logic         last_word;
    logic         blk_end;
    logic         last_blk;
    logic [W-1:0] word;

    store_fsm u_fsm (
        .clk           (clk),
        .rst           (rst),
        .block_valid_i (block_valid_i),
        .ready_i       (ready_i),
        .size_zero_i   (size_zero),
        .last_word_i   (last_word),
        .blk_end_i     (blk_end),
        .block_ready_o (block_ready_o),
        .valid_o       (valid_o),
        .job_done_o    (job_done_o),
        .load_first_o  (load_first),
        .load_next_o   (load_next),
        .shift_o       (shift),
        .state_o       (state)
    );

    store_datapath #(.W(W), .RATE_MAX(RATE_MAX)) u_dp (
        .clk            (clk),
        .rst            (rst),
        .block_in       (block_in),
        .output_size    (output_size),
        .operation_mode (operation_mode),
        .load_first_i   (load_first),
        .load_next_i    (load_next),
        .shift_i        (shift),
        .word_o         (word),
        .size_zero_o    (size_zero),
        .last_word_o    (last_word),
        .blk_end_o      (blk_end),
        .last_blk_o     (last_blk)
    );

    // Gating keeps data_out at 0 outside DUMP, matching its reset value.
    assign data_out     = valid_o ? word : '0;
    assign last_o       = valid_o && last_word;
    assign last_block_o = (state == ST_DUMP) && last_blk;
endmodule

// File: tb/tb_store_stage.sv
module tb_store_stage;
    import keccak_pkg::*;
    localparam int W        = w;
    localparam int RATE_MAX = RATE_SHAKE128;

    // ---------------- clock / reset ----------------
    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [RATE_MAX-1:0] block_in = '0;
    logic                block_valid_i = 1'b0;
    logic [31:0]         output_size = '0;
    logic [1:0]          operation_mode = '0;
    logic                block_ready_o;
    logic                last_block_o;
    logic [W-1:0]        data_out;
    logic                valid_o;
    logic                ready_i;
    logic                last_o;
    logic                job_done_o;

    always #5 clk = ~clk;

    store_stage #(.W(W), .RATE_MAX(RATE_MAX)) dut (
        .clk            (clk),
        .rst            (rst),
        .block_in       (block_in),
        .block_valid_i  (block_valid_i),
        .output_size    (output_size),
        .operation_mode (operation_mode),
        .block_ready_o  (block_ready_o),
        .last_block_o   (last_block_o),
        .data_out       (data_out),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .last_o         (last_o),
        .job_done_o     (job_done_o)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];      // {last, word}
    int mon_left;              // words of the job not yet transferred
    int mon_wpb;               // words per block for the job's mode
    int push_left;             // words of the job not yet queued
    int job_size;
    int xfer_cnt;
    int rdy_cnt;
    bit job_active;
    int rdy_mode = 0;          // 0: always ready, 1: random, 2: 1,0,0,1 pattern
    int rdy_phase = 0;
    logic [RATE_MAX-1:0] cur_blk;
    bit prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic prev_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic start_job(input int size, input logic [1:0] mode);
        output_size    = size;
        operation_mode = mode;
        job_size       = size;
        mon_wpb        = (mode == 2'b00) ? 21 : 17;
        push_left      = int'((longint'(size) + 63) / 64);
        mon_left       = push_left;
    endtask

    task automatic new_block();
        for (int i = 0; i < 21; i++) cur_blk[i*64 +: 64] = {$urandom(), $urandom()};
        block_in = cur_blk;
    endtask

    // Queue the words this block contributes: up to one block's worth of the remaining job.
    task automatic push_block();
        int n;
        logic [W-1:0] wd;
        bit lst;
        n = (push_left < mon_wpb) ? push_left : mon_wpb;
        for (int i = 0; i < n; i++) begin
            wd  = cur_blk[i*64 +: 64];
            lst = (push_left == 1);
`ifdef STORE_TAIL_MASK_EN
            if (lst && (job_size % 64 != 0)) wd = wd & ((64'd1 << (job_size % 64)) - 64'd1);
`endif
            exp_q.push_back({lst, wd});
            push_left--;
        end
    endtask

    // ---------------- drivers ----------------
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       ready_i = 1'b1;
                1:       ready_i = 1'($urandom_range(0, 1));
                default: begin
                    ready_i = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
                    rdy_phase++;
                end
            endcase
        end
    end

    // Returns just after the posedge at which the block was accepted.
    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (block_ready_o) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_job(input int size, input logic [1:0] mode, input int rmode);
        bit ok;
        int nblk;
        @(posedge clk);
        #1;
        rdy_mode = rmode;
        start_job(size, mode);
        nblk = (push_left == 0) ? 1 : (push_left + mon_wpb - 1) / mon_wpb;
        rdy_cnt = 0;
        for (int b = 0; b < nblk; b++) begin
            new_block();
            block_valid_i = 1'b1;
            wait_accept(ok);
            check("accept", 64'(ok), 64'd1);
            job_active = 1'b1;
            push_block();
            #1;
        end
        block_valid_i = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (job_done_o) begin
                ok = 1'b1;
                break;
            end
        end
        job_active = 1'b0;
        check("job_done", 64'(ok), 64'd1);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (job_active && block_ready_o) rdy_cnt++;
            if (prev_stall) begin
                check("hold_data", data_out, prev_data);
                check("hold_last", 64'(last_o), 64'(prev_last));
            end
            if (valid_o) begin
                check("ready_in_dump", 64'(block_ready_o), 64'd0);
                check("last_block", 64'(last_block_o), 64'(mon_left <= mon_wpb));
                if (ready_i) begin
                    prev_stall = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("extra_word_q", 64'(exp_q.size()), 64'd1);
                    end else begin
                        logic [W:0] e;
                        e = exp_q.pop_front();
                        check("data", data_out, e[W-1:0]);
                        check("last_o", 64'(last_o), 64'(e[W]));
                        mon_left--;
                        xfer_cnt++;
                    end
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = data_out;
                    prev_last  = last_o;
                end
            end else begin
                prev_stall = 1'b0;
                check("last_o_idle", 64'(last_o), 64'd0);
                check("last_block_idle", 64'(last_block_o), 64'd0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(block_ready_o), 64'd1);
        check({tag, "_valid"}, 64'(valid_o), 64'd0);
        check({tag, "_last"}, 64'(last_o), 64'd0);
        check({tag, "_lastblk"}, 64'(last_block_o), 64'd0);
        check({tag, "_done"}, 64'(job_done_o), 64'd0);
        check({tag, "_data"}, data_out, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: latency and done timing, SHAKE128, 4 words
        @(posedge clk);
        #1;
        rdy_mode = 0;
        start_job(256, 2'b00);
        new_block();
        block_valid_i = 1'b1;
        wait_accept(ok);
        check("t1_accept", 64'(ok), 64'd1);
        push_block();
        #1;
        block_valid_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("t1_valid", 64'(valid_o), 64'd1);
            check("t1_last", 64'(last_o), 64'(i == 4));
        end
        @(negedge clk);
        check("t1_done", 64'(job_done_o), 64'd1);
        check("t1_done_valid", 64'(valid_o), 64'd0);
        check("t1_done_ready", 64'(block_ready_o), 64'd0);
        @(negedge clk);
        check("t1_idle_done", 64'(job_done_o), 64'd0);
        check("t1_idle_ready", 64'(block_ready_o), 64'd1);

        // 2: SHAKE256, two blocks, single WAIT_BLK cycle
        run_job(2176, 2'b01, 0);
        check("t2_wait_cycles", 64'(rdy_cnt), 64'd1);

        // 3: partial final word
        run_job(100, 2'b00, 0);

        // 4: backpressure pattern 1,0,0,1
        rdy_phase = 0;
        run_job(640, 2'b00, 2);

        // 5: zero-length job
        @(posedge clk);
        #1;
        rdy_mode = 0;
        start_job(0, 2'b00);
        new_block();
        block_valid_i = 1'b1;
        wait_accept(ok);
        check("t5_accept", 64'(ok), 64'd1);
        push_block();
        #1;
        block_valid_i = 1'b0;
        @(negedge clk);
        check("t5_done", 64'(job_done_o), 64'd1);
        check("t5_valid", 64'(valid_o), 64'd0);
        @(negedge clk);
        check("t5_idle_done", 64'(job_done_o), 64'd0);
        check("t5_idle_ready", 64'(block_ready_o), 64'd1);
        check("t5_idle_valid", 64'(valid_o), 64'd0);

        // 6: reset in the middle of a full SHAKE128 block
        @(posedge clk);
        #1;
        start_job(1344, 2'b00);
        new_block();
        xfer_cnt = 0;
        block_valid_i = 1'b1;
        wait_accept(ok);
        check("t6_accept", 64'(ok), 64'd1);
        push_block();
        #1;
        block_valid_i = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (xfer_cnt >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        check("t6_reach_word5", 64'(ok), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_job(192, 2'b00, 0);

        // boundary sizes
        run_job(1344, 2'b00, 1);
        run_job(1345, 2'b00, 1);
        run_job(1088, 2'b01, 1);
        run_job(1, 2'b10, 0);
        run_job(64, 2'b11, 1);

        // randomized jobs
        for (int j = 0; j < 12; j++) begin
            run_job(int'($urandom_range(0, 3000)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
